// File: rtl/tdoa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_pkg
//  Description : Shared constants for the TDOA collector: timestamp width,
//                parameter defaults, FSM state encoding, index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdoa_pkg;

    localparam int unsigned c_TS_W       = 32;
    localparam int unsigned c_N_CH_DEF   = 4;
    localparam int unsigned c_WINDOW_DEF = 32'd50000;

    localparam int unsigned c_ST_W        = 2;
    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_COLLECT  = 2'd1;
    localparam logic [1:0]  c_ST_FIND_REF = 2'd2;
    localparam logic [1:0]  c_ST_PUBLISH  = 2'd3;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned f_ref_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdoa_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_collector_if
//  Description : Detector-side and result-side signals of the TDOA collector.
//                slave = collector view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdoa_collector_if
    import tdoa_pkg::*;
#(
    parameter int unsigned N_CH = c_N_CH_DEF
) ();

    localparam int unsigned c_REF_W = f_ref_w(N_CH);

    logic [N_CH-1:0]        det_valid;
    logic [c_TS_W*N_CH-1:0] det_time;
    logic [N_CH-1:0]        det_ack;
    logic                   out_valid;
    logic                   out_ack;
    logic [N_CH-1:0]        out_mask;
    logic [c_REF_W-1:0]     out_ref;
    logic [c_TS_W*N_CH-1:0] out_delta;

    modport slave (
        input  det_valid, det_time, out_ack,
        output det_ack, out_valid, out_mask, out_ref, out_delta
    );

    modport master (
        output det_valid, det_time, out_ack,
        input  det_ack, out_valid, out_mask, out_ref, out_delta
    );

endinterface
`default_nettype wire

// File: rtl/tdoa_min_finder.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_min_finder
//  Description : Sequential search for the earliest captured timestamp, one
//                channel per cycle. Strict unsigned less-than while scanning
//                upward makes the lowest index win ties. o_done pulses for one
//                cycle after the last channel has been examined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdoa_min_finder
    import tdoa_pkg::*;
#(
    parameter int unsigned N_CH = c_N_CH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [N_CH-1:0]              i_mask,
    input  logic [c_TS_W*N_CH-1:0]       i_time,
    output logic [f_ref_w(N_CH)-1:0]     o_ref,
    output logic                         o_done
);

    localparam int unsigned          c_REF_W    = f_ref_w(N_CH);
    localparam logic [c_REF_W-1:0]   c_LAST_IDX = c_REF_W'(N_CH - 1);

    logic                r_busy;
    logic                r_found;
    logic                r_done;
    logic [c_REF_W-1:0]  r_idx;
    logic [c_REF_W-1:0]  r_ref;
    logic [c_TS_W-1:0]   r_best;

    logic [c_TS_W-1:0]   w_cur_time;
    logic                w_take;

    assign w_cur_time = i_time[r_idx * c_TS_W +: c_TS_W];
    assign w_take     = r_busy && i_mask[r_idx] && (!r_found || (w_cur_time < r_best));

    // Scan state: restart on i_start, step one channel per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_found <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_ref   <= '0;
            r_best  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy  <= 1'b1;
                r_found <= 1'b0;
                r_idx   <= '0;
            end else if (r_busy) begin
                if (w_take) begin
                    r_best  <= w_cur_time;
                    r_ref   <= r_idx;
                    r_found <= 1'b1;
                end
                if (r_idx == c_LAST_IDX) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_ref  = r_ref;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/tdoa_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_collector
//  Description : Collects one timestamp per detector channel into a round,
//                closes the round when every channel is in or the window
//                expires, finds the earliest channel and publishes all
//                delays relative to it until the consumer acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdoa_collector
    import tdoa_pkg::*;
#(
    parameter int unsigned N_CH   = c_N_CH_DEF,
    parameter int unsigned WINDOW = c_WINDOW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    tdoa_collector_if.slave bus
);

    localparam int unsigned        c_REF_W    = f_ref_w(N_CH);
    localparam logic [c_TS_W-1:0]  c_WIN_LAST = c_TS_W'(WINDOW - 1);

    logic [c_ST_W-1:0]       r_state;
    logic [c_ST_W-1:0]       w_next_state;

    logic [N_CH-1:0]         r_armed;
    logic [N_CH-1:0]         r_captured;
    logic [N_CH-1:0]         r_det_ack;
    logic [c_TS_W*N_CH-1:0]  r_time;
    logic [c_TS_W-1:0]       r_win_cnt;

    logic                    r_out_valid;
    logic [N_CH-1:0]         r_out_mask;
    logic [c_REF_W-1:0]      r_out_ref;
    logic [c_TS_W*N_CH-1:0]  r_out_delta;

    logic [N_CH-1:0]         w_cap;
    logic                    w_any_cap;
    logic                    w_close;
    logic                    w_cap_en;
    logic                    w_win_load;
    logic                    w_win_inc;
    logic                    w_start_find;
    logic                    w_load_out;
    logic                    w_round_end;
    logic [c_REF_W-1:0]      w_find_ref;
    logic                    w_find_done;
    logic [c_TS_W-1:0]       w_ref_time;
    logic [c_TS_W*N_CH-1:0]  w_delta;

    // A channel is taken only once per valid assertion: it must have been
    // seen low (armed) and not already be part of the current round.
    assign w_cap     = {N_CH{w_cap_en}} & bus.det_valid & r_armed & ~r_captured;
    assign w_any_cap = |w_cap;
    assign w_close   = (&r_captured) || (r_win_cnt == c_WIN_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_any_cap)   w_next_state = c_ST_COLLECT;
            c_ST_COLLECT:  if (w_close)     w_next_state = c_ST_FIND_REF;
            c_ST_FIND_REF: if (w_find_done) w_next_state = c_ST_PUBLISH;
            c_ST_PUBLISH:  if (bus.out_ack) w_next_state = c_ST_IDLE;
            default:                        w_next_state = c_ST_IDLE;
        endcase
    end

    // State decode into datapath controls.
    always_comb begin
        w_cap_en     = 1'b0;
        w_win_load   = 1'b0;
        w_win_inc    = 1'b0;
        w_start_find = 1'b0;
        w_load_out   = 1'b0;
        w_round_end  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cap_en   = 1'b1;
                w_win_load = w_any_cap;
            end
            c_ST_COLLECT: begin
                w_cap_en     = 1'b1;
                w_win_inc    = 1'b1;
                w_start_find = w_close;
            end
            c_ST_FIND_REF: w_load_out  = w_find_done;
            c_ST_PUBLISH:  w_round_end = bus.out_ack;
            default: ;
        endcase
    end

    // Per-channel arming, capture bookkeeping, timestamp store and ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed    <= '0;
            r_captured <= '0;
            r_det_ack  <= '0;
            r_time     <= '0;
        end else begin
            r_det_ack <= w_cap;
            r_armed   <= (r_armed & ~w_cap) | ~bus.det_valid;
            if (w_round_end) begin
                r_captured <= '0;
            end else begin
                r_captured <= r_captured | w_cap;
            end
            for (int i = 0; i < int'(N_CH); i++) begin
                if (w_cap[i]) begin
                    r_time[i*c_TS_W +: c_TS_W] <= bus.det_time[i*c_TS_W +: c_TS_W];
                end
            end
        end
    end

    // Window counter: zero on the opening capture, counts through COLLECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else if (w_win_load) begin
            r_win_cnt <= '0;
        end else if (w_win_inc) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    tdoa_min_finder #(
        .N_CH (N_CH)
    ) u_min_finder (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start_find),
        .i_mask  (r_captured),
        .i_time  (r_time),
        .o_ref   (w_find_ref),
        .o_done  (w_find_done)
    );

    // Delays relative to the reference, modulo 2^32; absent channels read 0.
    always_comb begin
        w_ref_time = r_time[w_find_ref * c_TS_W +: c_TS_W];
        w_delta    = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (r_captured[i]) begin
                w_delta[i*c_TS_W +: c_TS_W] = r_time[i*c_TS_W +: c_TS_W] - w_ref_time;
            end
        end
    end

    // Result registers: loaded once at the end of the search, held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_out_ref   <= '0;
            r_out_delta <= '0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_mask  <= r_captured;
            r_out_ref   <= w_find_ref;
            r_out_delta <= w_delta;
        end else if (w_round_end) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.det_ack   = r_det_ack;
    assign bus.out_valid = r_out_valid;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_ref   = r_out_ref;
    assign bus.out_delta = r_out_delta;

endmodule
`default_nettype wire

// File: tb/tb_tdoa_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdoa_collector
//  Description : Self-checking bench for tdoa_collector (N_CH=4, WINDOW=10).
//                Directed scenarios followed by randomized rounds checked
//                against a round-level timing and arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdoa_collector;
    import tdoa_pkg::*;

    localparam int NCH = 4;
    localparam int WIN = 10;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ack0_cnt = 0;

    // Round description consumed by run_round.
    logic [3:0]  m_fire;
    int          m_off [4];
    logic [31:0] m_t   [4];
    int          m_hold;
    bit          m_rand_ack;

    tdoa_collector_if #(.N_CH(NCH)) bus ();

    tdoa_collector #(
        .N_CH   (NCH),
        .WINDOW (WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.det_ack[0] === 1'b1) ack0_cnt++;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < bound) begin
            cycle();
            n++;
        end
        chk(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_ack(input string tag);
        bus.out_ack = 1'b1;
        cycle();
        bus.out_ack = 1'b0;
        chk(tag, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic set_time(input int ch, input logic [31:0] t);
        bus.det_time[ch*32 +: 32] = t;
    endtask

    // Drives one round and checks acks, out_valid timing and result fields.
    // Iteration c observes the state just after edge c; a channel firing at
    // offset k is sampled at edge k+1.
    task automatic run_round();
        bit          cap [4];
        logic [3:0]  exp_mask;
        logic [3:0]  exp_ack;
        logic [31:0] exp_delta [4];
        int          klast, ec, pub, last, ref_i;
        bit          all_in, exp_valid, is_min;
        exp_mask = '0;
        klast    = 0;
        all_in   = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            cap[i] = m_fire[i] && (m_off[i] <= WIN);
            if (cap[i]) begin
                exp_mask[i] = 1'b1;
                if (m_off[i] > klast) klast = m_off[i];
            end else begin
                all_in = 1'b0;
            end
        end
        // Opening capture is at edge 1; close is the window end or the edge
        // after the last channel arrives, whichever is sooner.
        ec   = 1 + (all_in ? ((klast + 1 < WIN) ? klast + 1 : WIN) : WIN);
        pub  = ec + NCH + 1;
        last = pub + m_hold + 1;
        // Reference: lowest index whose time no captured channel beats.
        ref_i = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cap[i]) begin
                is_min = 1'b1;
                for (int j = 0; j < NCH; j++)
                    if (cap[j] && m_t[j] < m_t[i]) is_min = 1'b0;
                if (is_min) ref_i = i;
            end
        end
        for (int i = 0; i < NCH; i++)
            exp_delta[i] = cap[i] ? (m_t[i] - m_t[ref_i]) : 32'd0;

        bus.det_valid = '0;
        bus.out_ack   = 1'b0;
        cycle();
        cycle();
        for (int c = 0; c <= last; c++) begin
            exp_ack = '0;
            for (int i = 0; i < NCH; i++)
                if (cap[i] && (m_off[i] + 1 == c)) exp_ack[i] = 1'b1;
            chk("rnd_ack", 32'(bus.det_ack), 32'(exp_ack));
            exp_valid = (c >= pub) && (c < last);
            chk("rnd_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rnd_mask", 32'(bus.out_mask), 32'(exp_mask));
                chk("rnd_ref", 32'(bus.out_ref), 32'(ref_i));
                for (int i = 0; i < NCH; i++)
                    chk("rnd_delta", bus.out_delta[i*32 +: 32], exp_delta[i]);
            end
            for (int i = 0; i < NCH; i++) begin
                bus.det_valid[i] = m_fire[i] && (m_off[i] == c);
                set_time(i, bus.det_valid[i] ? m_t[i] : $urandom());
            end
            if (c == last - 1)               bus.out_ack = 1'b1;
            else if (c < pub && m_rand_ack)  bus.out_ack = ($urandom_range(0, 2) == 0);
            else                             bus.out_ack = 1'b0;
            if (c < last) cycle();
        end
        bus.det_valid = '0;
        bus.out_ack   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.det_valid = 4'b1000;
        bus.det_time  = '0;
        bus.out_ack   = 1'b0;
        repeat (3) cycle();

        // Reset state.
        chk("rst_ack", 32'(bus.det_ack), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mask", 32'(bus.out_mask), 32'd0);
        chk("rst_ref", 32'(bus.out_ref), 32'd0);
        chk("rst_delta", bus.out_delta[31:0] | bus.out_delta[63:32] |
                         bus.out_delta[95:64] | bus.out_delta[127:96], 32'd0);

        // ch3 high since reset was never seen low: no capture.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("noarm_ack", 32'(bus.det_ack), 32'd0);
        end
        bus.det_valid = '0;
        cycle();

        // Four channels in different cycles.
        m_fire = 4'b1111; m_off = '{0, 2, 4, 6}; m_t = '{100, 103, 98, 110};
        m_hold = 3; m_rand_ack = 1'b0;
        run_round();
        chk("d35_ref", 32'(bus.out_ref), 32'd2);
        chk("d35_mask", 32'(bus.out_mask), 32'hF);
        chk("d35_d0", bus.out_delta[31:0], 32'd2);
        chk("d35_d1", bus.out_delta[63:32], 32'd5);
        chk("d35_d2", bus.out_delta[95:64], 32'd0);
        chk("d35_d3", bus.out_delta[127:96], 32'd12);

        // Single channel, round closed by the window.
        m_fire = 4'b0010; m_off = '{0, 0, 0, 0}; m_t = '{1, 500, 3, 4};
        m_hold = 1;
        run_round();
        chk("d36_mask", 32'(bus.out_mask), 32'h2);
        chk("d36_ref", 32'(bus.out_ref), 32'd1);
        chk("d36_d1", bus.out_delta[63:32], 32'd0);

        // Simultaneous equal timestamps: lowest index is the reference.
        m_fire = 4'b1001; m_off = '{0, 0, 0, 0}; m_t = '{77, 0, 0, 77};
        m_hold = 0;
        run_round();
        chk("d37_ref", 32'(bus.out_ref), 32'd0);
        chk("d37_mask", 32'(bus.out_mask), 32'h9);

        // ch0 held high across two rounds: acked once only.
        ack0_cnt = 0;
        bus.det_valid = 4'b0001;
        set_time(0, 32'd55);
        cycle();
        wait_valid("d38_valid1", 40);
        chk("d38_mask1", 32'(bus.out_mask), 32'h1);
        do_ack("d38_clr1");
        bus.det_valid = 4'b0011;
        set_time(1, 32'd66);
        cycle();
        bus.det_valid = 4'b0001;
        wait_valid("d38_valid2", 40);
        chk("d38_mask2", 32'(bus.out_mask), 32'h2);
        do_ack("d38_clr2");
        chk("d38_ack0_count", 32'(ack0_cnt), 32'd1);
        bus.det_valid = '0;
        cycle();
        cycle();

        // Long PUBLISH while ch2 asks for service.
        bus.det_valid = 4'b0001;
        set_time(0, 32'd7);
        cycle();
        bus.det_valid = '0;
        wait_valid("d39_valid", 40);
        bus.det_valid = 4'b0100;
        set_time(2, 32'h1234);
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("d39_ack2", 32'(bus.det_ack[2]), 32'd0);
            chk("d39_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("d39_hold_mask", 32'(bus.out_mask), 32'h1);
            chk("d39_hold_ref", 32'(bus.out_ref), 32'd0);
            chk("d39_hold_d0", bus.out_delta[31:0], 32'd0);
        end
        do_ack("d39_clr");
        chk("d39_idle_ack", 32'(bus.det_ack), 32'd0);
        cycle();
        chk("d39_ack_after", 32'(bus.det_ack), 32'h4);
        bus.det_valid = '0;
        wait_valid("d39_valid2", 40);
        chk("d39_mask2", 32'(bus.out_mask), 32'h4);
        do_ack("d39_clr2");
        cycle();

        // Reset in the middle of a round.
        bus.det_valid = 4'b0001;
        cycle();
        bus.det_valid = 4'b0011;
        cycle();
        cycle();
        bus.det_valid = 4'b1111;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("d40_ack", 32'(bus.det_ack), 32'd0);
        chk("d40_valid", 32'(bus.out_valid), 32'd0);
        chk("d40_mask", 32'(bus.out_mask), 32'd0);
        chk("d40_ref", 32'(bus.out_ref), 32'd0);
        chk("d40_delta", bus.out_delta[31:0] | bus.out_delta[63:32] |
                         bus.out_delta[95:64] | bus.out_delta[127:96], 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("d40_noack", 32'(bus.det_ack), 32'd0);
            chk("d40_novalid", 32'(bus.out_valid), 32'd0);
        end
        bus.det_valid = '0;
        cycle();
        bus.det_valid = 4'b1000;
        set_time(3, 32'd42);
        cycle();
        chk("d40_rearm_ack", 32'(bus.det_ack), 32'h8);
        bus.det_valid = '0;
        wait_valid("d40_valid", 40);
        chk("d40_mask2", 32'(bus.out_mask), 32'h8);
        chk("d40_ref2", 32'(bus.out_ref), 32'd3);
        do_ack("d40_clr");

        // Randomized rounds, including late arrivals and stray out_ack.
        for (int r = 0; r < 40; r++) begin
            int i0;
            i0     = $urandom_range(0, 3);
            m_fire = 4'($urandom_range(0, 15));
            m_fire[i0] = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                m_off[i] = (i == i0) ? 0 : $urandom_range(0, WIN + 4);
                m_t[i]   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            end
            m_hold     = $urandom_range(0, 5);
            m_rand_ack = 1'b1;
            run_round();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
